// File: rtl/pattern_tx_pkg.sv
// -----------------------------------------------------------------------------
// pattern_tx_pkg
//   Shared definitions for the serial pattern transmitter.
//   - state_t : FSM state encoding (IDLE / SEND / DONE)
//   - eff_len : maps a requested pattern length onto the length actually sent
// -----------------------------------------------------------------------------
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // A length of 0, or anything longer than the pattern register, means
    // "send the whole register". Clamping here keeps the last-bit compare in
    // range for every later cycle of the pass.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned width);
        if ((len == 0) || (len > width)) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/pattern_tx_if.sv
// -----------------------------------------------------------------------------
// pattern_tx_if
//   Valid/ready load port of the serial pattern transmitter.
//   Signals:
//     load_valid  producer -> tx  : pattern offered
//     load_ready  tx -> producer  : transmitter can accept a pattern
//     load_data   producer -> tx  : pattern, bit 0 sent first
//     load_len    producer -> tx  : bits to send (0 or >WIDTH means WIDTH)
//   Modports:
//     master : pattern producer
//     slave  : pattern_tx
// -----------------------------------------------------------------------------
interface pattern_tx_if #(
    parameter int unsigned WIDTH = 60
);
    localparam int unsigned LW = $clog2(WIDTH + 1);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LW-1:0]    load_len;

    modport master (
        output load_valid,
        output load_data,
        output load_len,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_len,
        output load_ready
    );

endinterface

// File: rtl/pattern_tx_tick.sv
// -----------------------------------------------------------------------------
// pattern_tx_tick
//   Bit-period counter. Counts 0..DIV-1 while enabled and flags the final
//   clock of each serial bit period.
//   Ports:
//     clk    in  : clock
//     reset  in  : synchronous, active-high reset
//     clear  in  : restart the bit period (new pattern accepted)
//     en     in  : count enable (transmitter is sending)
//     tick   out : high on the last clock of a bit period
// -----------------------------------------------------------------------------
module pattern_tx_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    // With DIV=1 the count never leaves 0, so tick simply follows en.
    assign tick = en && (div_cnt_q == TC);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = tick ? '0 : (div_cnt_q + CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// -----------------------------------------------------------------------------
// pattern_tx
//   Serial pattern transmitter. Accepts a parallel pattern on a valid/ready
//   port and shifts it out LSB-first, one bit every DIV clocks. Supports a
//   variable pattern length, gapless repeat and abort.
//   Ports:
//     clk        in  : clock, rising edge
//     reset      in  : synchronous, active-high reset
//     load       if  : pattern_tx_if.slave load port (valid/ready/data/len)
//     repeat_en  in  : restart the pattern after its last bit
//     stop       in  : abort the current transmission
//     o_d        out : serial data
//     o_valid    out : o_d carries a pattern bit
//     o_last     out : current bit is the last bit of the pass
//     busy       out : SEND state active
//     done       out : one-cycle pulse when a pass completes without abort
//
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | waiting for a pattern, load_ready high
//   SEND  | shifting bits out, one per bit period
//   DONE  | one cycle after a finished pass, pulses done
// -----------------------------------------------------------------------------
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 60,
    parameter int unsigned DIV   = 1
) (
    input  logic               clk,
    input  logic               reset,
    pattern_tx_if.slave        load,
    input  logic               repeat_en,
    input  logic               stop,
    output logic               o_d,
    output logic               o_valid,
    output logic               o_last,
    output logic               busy,
    output logic               done
);

    localparam int unsigned LW = $clog2(WIDTH + 1);
    localparam int unsigned IW = $clog2(WIDTH);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  reload_q, reload_d;
    logic [LW-1:0]     len_q, len_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;

    logic              o_d_q, o_d_d;
    logic              o_valid_q, o_valid_d;
    logic              o_last_q, o_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              load_fire;
    logic              tick;
    logic              last_bit;
    logic              advance;

    assign load.load_ready = (state_q == IDLE) && !reset;
    assign load_fire       = load.load_valid && load.load_ready;

    // len_q is never 0 after a load, so len_q-1 cannot underflow.
    assign last_bit = (LW'(bit_idx_q) == (len_q - LW'(1)));
    assign advance  = (state_q == SEND) && !stop && tick;

    pattern_tx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (load_fire),
        .en    (state_q == SEND),
        .tick  (tick)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_fire) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // stop wins over both the bit tick and the repeat decision
                if (stop) begin
                    state_d = IDLE;
                end else if (tick && last_bit) begin
                    state_d = repeat_en ? SEND : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        shift_d   = shift_q;
        reload_d  = reload_q;
        len_d     = len_q;
        bit_idx_d = bit_idx_q;
        if (load_fire) begin
            shift_d   = load.load_data;
            reload_d  = load.load_data;
            len_d     = LW'(eff_len(32'(load.load_len), WIDTH));
            bit_idx_d = '0;
        end else if (advance) begin
            if (last_bit) begin
                // Reloading on the final tick makes the next pass start
                // in the very next cycle, so repeats have no gap.
                shift_d   = repeat_en ? reload_q : (shift_q >> 1);
                bit_idx_d = '0;
            end else begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            reload_q  <= '0;
            len_q     <= '0;
            bit_idx_q <= '0;
        end else begin
            shift_q   <= shift_d;
            reload_q  <= reload_d;
            len_q     <= len_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // -------------------------------------------------------------- outputs
    // Outputs are registered from next-cycle values so they line up with the
    // state they describe.
    always_comb begin
        o_d_d     = 1'b0;
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_d)
            SEND: begin
                o_d_d     = shift_d[0];
                o_valid_d = 1'b1;
                o_last_d  = (LW'(bit_idx_d) == (len_d - LW'(1)));
                busy_d    = 1'b1;
            end
            DONE: begin
                done_d    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_d_q     <= 1'b0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            o_d_q     <= o_d_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_d     = o_d_q;
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter: accepts a parallel bit pattern over a valid/ready load port and shifts it out LSB-first on a single-bit serial line, one bit per programmable bit period. It is the producing end of the serial bit stream consumed by the team's sequence-detector FSMs; its `o_d` drives their `i_d` input. It supports variable pattern length, continuous repeat and abort.

## Interface
- `WIDTH`, 60, maximum pattern length in bits (≥2)
- `DIV`, 1, clocks per serial bit (≥1)
- `LW`, `$clog2(WIDTH+1)`, width of `load_len` (derived; not overridden)
- `clk` in 1: single clock; all logic on its rising edge
- `reset` in 1: synchronous, active-high reset
- `load_valid` in 1: pattern offered
- `load_ready` out 1: block can accept a pattern
- `load_data` in WIDTH: pattern; bit 0 is sent first
- `load_len` in LW: bits to send. 0 or >WIDTH means WIDTH.
- `repeat_en` in 1: restart the pattern after its last bit
- `stop` in 1: abort the current transmission
- `o_d` out 1: serial data
- `o_valid` out 1: `o_d` carries a pattern bit
- `o_last` out 1: current bit is the last bit of the pass
- `busy` out 1: SEND state active
- `done` out 1: one-cycle pulse when a pass completes without abort

## Operation
- States:
  - IDLE: waits for a pattern.
  - SEND: shifts bits out.
  - DONE: one cycle, pulses `done`.
- Reset: state IDLE; `o_d`, `o_valid`, `o_last`, `busy`, `done` all 0. Shift register and counters are cleared. `load_ready` = (state==IDLE) && !reset. `load_valid` is ignored while `reset` is high.
- IDLE → SEND on `load_valid && load_ready`:
  - `load_data` is captured into the shift and reload registers.
  - The effective length is captured as `len_q`.
  - `bit_idx` = 0 and `div_cnt` = 0.
- SEND:
  - `o_d` = shift[0], `o_valid` = 1, `busy` = 1.
  - `o_last` = (`bit_idx` == `len_q`−1).
  - `div_cnt` counts 0..DIV−1. At DIV−1 (tick), the register shifts right and `bit_idx` increments.
- End of pass (tick while `o_last`):
  - If `repeat_en` = 1, reload from the reload register, `bit_idx` = 0, stay in SEND. There are no gap cycles.
  - Otherwise go to DONE.
- DONE: `done` = 1, `o_valid` = 0, `o_d` = 0. Next state is IDLE.
- `stop` in SEND: next state IDLE, `o_valid` = 0, no `done` pulse. `stop` has priority over tick and over repeat. `stop` in IDLE or DONE is ignored.
- `repeat_en` is sampled only on the final tick of a pass. Deasserting it mid-pass lets the current pass finish normally.
- Outside SEND: `o_d` = 0, `o_valid` = 0, `o_last` = 0.
- Width rules:
  - `bit_idx` is `$clog2(WIDTH)` bits.
  - `div_cnt` is `max(1,$clog2(DIV))` bits and wraps to 0 at each tick.
  - `len_q` compare never overflows because length is clamped at load.

## Timing
- All outputs are registered except `load_ready`.
- Handshake accepted at edge N → bit 0 is valid in cycle N+1.
- Bit k occupies cycles N+1+k·DIV … N+(k+1)·DIV.
- Last bit (L = `len_q`) ends in cycle N+L·DIV. `done` is high in cycle N+L·DIV+1. `load_ready` is 1 from cycle N+L·DIV+2.
- Back-to-back patterns need 2 idle cycles between passes (DONE, then IDLE handshake), unless `repeat_en` is used.
- `stop` sampled high at edge M → `o_valid` = 0 in cycle M+1 and `load_ready` = 1 in cycle M+1.
- `reset` sampled at any edge, in any state → reset values in the following cycle. It overrides `stop`, load and tick.

## Structure
- Package `pattern_tx_pkg`:
  - state encoding constants IDLE=2'd0, SEND=2'd1, DONE=2'd2
  - length-clamp function `eff_len(len, WIDTH)`
- Sub-module `pattern_tx_tick`: the DIV bit-period counter.
  - Inputs: `clk`, `reset`, `clear`, `en`.
  - Output: one-cycle `tick` at count DIV−1.
  - With DIV=1, `tick` is constant 1 while `en` is high.
- Top level: FSM, shift register, reload register, `bit_idx`, output registers.

## Test plan
- WIDTH=8, DIV=1, load 8'b1011_0010 len 8 at edge N:
  - `o_d` = 0,1,0,0,1,1,0,1 in cycles N+1..N+8
  - `o_last` only at N+8
  - `done` at N+9
  - `load_ready` at N+10
- DIV=3, load 3'b101 len 3: `o_d` = 1,1,1,0,0,0,1,1,1, then `done` one cycle later.
- Repeat, len 2, data 2'b10, `repeat_en` = 1:
  - `o_d` = 0,1,0,1,0,1… with no gap
  - drop `repeat_en` mid-pass → current pass completes, one `done`, then IDLE.
- `stop` asserted during bit 3 of an 8-bit pass:
  - next cycle `o_valid` = 0, `busy` = 0, `load_ready` = 1
  - `done` never pulses
  - a new load is accepted the same cycle.
- `reset` pulsed mid-SEND with `load_valid` high:
  - next cycle all outputs 0
  - no capture while reset is high
  - first cycle after release `load_ready` = 1.
- Length clamp:
  - len 0 → exactly WIDTH bits sent
  - len WIDTH+3 (WIDTH=8) → exactly 8 bits sent
  - `o_last` on bit 7 in both cases.
